// File: rtl/imem_loader.sv
// imem_loader: streams a header, N program words and (optional) checksum into instruction memory, then starts the CPU.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_req,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        cpu_start,
    output logic        busy,
    output logic        error
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] START = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK   = 3'd3;
    localparam logic [2:0] AFTER_DATA = CHK;
`else
    localparam logic [2:0] AFTER_DATA = START;
`endif

    logic [2:0] state;
    logic [8:0] cnt, n;
    logic       wr_pend;
    logic       xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state == HDR) || (state == DATA) || (state == CHK);
`else
    assign in_ready = (state == HDR) || (state == DATA);
`endif
    assign xfer      = in_valid && in_ready;
    assign busy      = in_ready || (state == START);
    assign cpu_start = (state == START);
    assign cpu_hold  = !((state == START) || (state == DONE));
    assign error     = (state == ERR);
    // a reset arriving in the write cycle must kill the write already registered
    assign wr_en     = wr_pend && !reset;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum, total;
    assign total = sum + in_data;
    always_ff @(posedge clock) begin
        if (reset)
            sum <= 16'd0;
        else if (load_req && ((state == IDLE) || (state == DONE) || (state == ERR)))
            sum <= 16'd0;
        else if (xfer && ((state == HDR) || (state == DATA)))
            sum <= total;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 9'd0;
            n       <= 9'd0;
            wr_pend <= 1'b0;
            wr_addr <= 8'd0;
            wr_data <= 16'd0;
        end else begin
            wr_pend <= (state == DATA) && xfer;
            if ((state == DATA) && xfer) begin
                wr_addr <= cnt[7:0];
                wr_data <= in_data;
            end
            case (state)
                IDLE, DONE, ERR: if (load_req) begin
                    state <= HDR;
                    cnt   <= 9'd0;
                end
                HDR: if (xfer) begin
                    n     <= in_data[8:0];
                    state <= (in_data[8:0] == 9'd0 || in_data[8:0] > 9'(DEPTH)) ? ERR : DATA;
                end
                DATA: if (xfer) begin
                    cnt <= cnt + 9'd1;
                    if (cnt == n - 9'd1)
                        state <= AFTER_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (xfer)
                    state <= (total == 16'd0) ? START : ERR;
`endif
                START:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 128, instruction-memory words addressable; SHALL be ≤256.
REQ-002 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load_req  input  1  one-cycle request to begin a load session.
REQ-005 Port: in_valid  input  1  in_data holds a word.
REQ-006 Port: in_data  input  16  stream word (header, program word, or checksum).
REQ-007 Port: in_ready  output  1  loader accepts a word this cycle.
REQ-008 Port: wr_en  output  1  instruction-memory write strobe.
REQ-009 Port: wr_addr  output  8  instruction-memory word address.
REQ-010 Port: wr_data  output  16  instruction word to write.
REQ-011 Port: cpu_hold  output  1  holds the CPU in reset while high.
REQ-012 Port: cpu_start  output  1  one-cycle start pulse to the CPU.
REQ-013 Port: busy  output  1  session in progress (HDR, DATA, CHK, START).
REQ-014 Port: error  output  1  last session rejected; sticky until next load_req or reset.

Function
REQ-015 States SHALL be IDLE, HDR, DATA, CHK, START, DONE, ERR.
REQ-016 A transfer SHALL occur only on a cycle with in_valid and in_ready both high.
REQ-017 in_ready SHALL be high exactly in HDR, DATA and CHK; in_data SHALL be ignored elsewhere.
REQ-018 IDLE/DONE/ERR + load_req -> HDR; clear word counter, clear error, assert cpu_hold; load_req in other states SHALL be ignored.
REQ-019 HDR transfer: N = in_data[8:0]; N in 1..DEPTH -> DATA; N = 0 or N > DEPTH -> ERR; in_data[15:9] ignored.
REQ-020 DATA transfer k (k = 0..N-1): one cycle later wr_en = 1, wr_addr = k, wr_data = word; exactly 1-cycle write latency.
REQ-021 wr_en SHALL be high only the cycle after a DATA transfer; wr_addr/wr_data hold last values otherwise.
REQ-022 After transfer N-1: -> CHK if checksum compiled in, else -> START.
REQ-023 START SHALL last one cycle, drive cpu_start = 1, deassert cpu_hold from the same cycle, then -> DONE.
REQ-024 DONE: cpu_hold = 0, cpu_start = 0, busy = 0, until load_req.
REQ-025 ERR: error = 1, cpu_hold = 1, no further writes, until load_req.
REQ-026 Words already written before ERR SHALL remain in memory; no rollback.
REQ-027 A stalled stream (in_valid low) SHALL hold state indefinitely; no timeout.
REQ-028 Word counter SHALL be 9 bits; N = DEPTH SHALL write addresses 0..DEPTH-1 with no wrap.

Reset
REQ-029 reset SHALL force IDLE, cpu_hold = 1, cpu_start = 0, wr_en = 0, wr_addr = 0, wr_data = 0, error = 0, busy = 0, in_ready = 0, counters and checksum = 0.
REQ-030 reset mid-session SHALL abort within the same edge; a pending write from the prior cycle's transfer SHALL be suppressed.
REQ-031 reset and load_req in the same cycle: reset SHALL win; state is IDLE next cycle.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: 16-bit modulo sum of header and all N data words is accumulated; the CHK transfer adds in_data; total = 0 -> START, else -> ERR.
REQ-033 Macro undefined: CHK state, accumulator and comparison SHALL be absent; DATA -> START directly; session accepts exactly N+1 words.

Verification
REQ-034 Reset, load_req, stream 3, 0x1111, 0x2222, 0x3333 (macro off) -> writes addr 0,1,2 with those data, one cycle after each transfer; cpu_start pulses once; cpu_hold low afterward.
REQ-035 Header 0 or 129 (DEPTH 128) -> ERR, error = 1, no wr_en, cpu_hold stays 1; next load_req clears error.
REQ-036 Macro on, header 2, data 0x0001, 0x0002, checksum 0xFFFB -> START; checksum 0xFFFC -> ERR, addr 0,1 still written.
REQ-037 Header 128, 128 words with random in_valid gaps -> last write addr 127, exactly 128 wr_en pulses, no extra transfers (in_ready low after last).
REQ-038 reset asserted the cycle after data transfer 1 of 4 -> no write for that word, state IDLE, cpu_hold = 1, in_ready = 0.
REQ-039 load_req pulsed during DATA -> ignored; session completes normally.
